// File: rtl/fprint_comparator_pkg.sv
// Shared fingerprint-comparator defaults and FSM state type.
// The four widths carry the historical crc_defines.v values.
package fprint_comparator_pkg;

  localparam int CRC_RAM_ADDRESS_WIDTH = 4;
  localparam int CRC_WIDTH             = 32;
  localparam int CRC_KEY_SIZE          = 16;
  localparam int CRC_KEY_WIDTH         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_COMPARE,
    ST_VERIFY,
    ST_COOLDOWN,
    ST_MISMATCH
  } state_e;

endpackage

// File: rtl/fprint_lowest_set.sv
// Priority encoder: index of the lowest set bit of vec, 0 when vec is all zero.
module fprint_lowest_set #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fprint_comparator.sv
// Pairs core-0/core-1 fingerprint FIFO entries, flags mismatches and reports verified tasks.
// Optional macro FPRINT_OVERFLOW_DETECT_EN: hold head and set sticky overflow_err on push into a full FIFO.
module fprint_comparator
  import fprint_comparator_pkg::*;
#(
  parameter int RAM_AW   = CRC_RAM_ADDRESS_WIDTH,
  parameter int CRC_W    = CRC_WIDTH,
  parameter int KEY_SIZE = CRC_KEY_SIZE,
  parameter int KEY_W    = CRC_KEY_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                logical_core_id,
  input  logic                increment_head_pointer,
  output logic                increment_hp_ack,
  output logic [RAM_AW-1:0]   fprint_head_pointer,
  output logic [RAM_AW-1:0]   comp_tail_pointer0,
  output logic [RAM_AW-1:0]   comp_tail_pointer1,
  input  logic [CRC_W-1:0]    fprint0,
  input  logic [CRC_W-1:0]    fprint1,
  input  logic [KEY_SIZE-1:0] checkin_reg_out,
  output logic                comp_task_verified,
  output logic [KEY_W-1:0]    comp_task,
  input  logic                fprint_reg_ack,
  output logic                mismatch,
  output logic [KEY_W-1:0]    mismatch_task,
  input  logic                mismatch_clear,
  output logic                overflow_err
);

  state_e            state;
  logic [RAM_AW-1:0] head0;
  logic [RAM_AW-1:0] head1;
  logic [RAM_AW-1:0] tail;
  logic [RAM_AW-1:0] head0_nx;
  logic [RAM_AW-1:0] head1_nx;
  logic [RAM_AW-1:0] tail_nx;
  logic              empty0;
  logic              empty1;
  logic              pair_avail;
  logic              push;
  logic              push_ok;
  logic [KEY_W-1:0]  low_idx;

  fprint_lowest_set #(
    .WIDTH (KEY_SIZE),
    .IDX_W (KEY_W)
  ) u_lowest (
    .vec (checkin_reg_out),
    .idx (low_idx)
  );

  assign head0_nx   = head0 + 1'b1;
  assign head1_nx   = head1 + 1'b1;
  assign tail_nx    = tail + 1'b1;
  assign empty0     = (head0 == tail);
  assign empty1     = (head1 == tail);
  assign pair_avail = ~empty0 & ~empty1;

  // A new request is one the ack register has not yet answered.
  assign push = increment_head_pointer & ~increment_hp_ack;

`ifdef FPRINT_OVERFLOW_DETECT_EN
  logic target_full;
  logic overflow_q;

  assign target_full  = logical_core_id ? (head1_nx == tail) : (head0_nx == tail);
  assign push_ok      = push & ~target_full;
  assign overflow_err = overflow_q;
`else
  assign push_ok      = push;
  assign overflow_err = 1'b0;
`endif

  assign fprint_head_pointer = logical_core_id ? head1 : head0;
  assign comp_tail_pointer0  = tail;
  assign comp_tail_pointer1  = tail;

  // Head updates come first so a later FSM resync of head1 on the same edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      head0              <= '0;
      head1              <= '0;
      tail               <= '0;
      increment_hp_ack   <= 1'b0;
      comp_task_verified <= 1'b0;
      comp_task          <= '0;
      mismatch           <= 1'b0;
      mismatch_task      <= '0;
`ifdef FPRINT_OVERFLOW_DETECT_EN
      overflow_q         <= 1'b0;
`endif
    end else begin
      increment_hp_ack <= push;
      if (push_ok && !logical_core_id) head0 <= head0_nx;
      if (push_ok &&  logical_core_id) head1 <= head1_nx;
`ifdef FPRINT_OVERFLOW_DETECT_EN
      if (push && target_full) overflow_q <= 1'b1;
`endif

      case (state)
        ST_IDLE: begin
          if (pair_avail) begin
            state <= ST_READ;
          end else if ((checkin_reg_out != '0) && empty0 && empty1) begin
            state              <= ST_VERIFY;
            comp_task          <= low_idx;
            comp_task_verified <= 1'b1;
          end
        end
        ST_READ: state <= ST_COMPARE;
        ST_COMPARE: begin
          if (fprint0 == fprint1) begin
            tail  <= tail_nx;
            state <= ST_IDLE;
          end else begin
            mismatch      <= 1'b1;
            mismatch_task <= low_idx;
            tail          <= head0;
            state         <= ST_MISMATCH;
          end
        end
        ST_VERIFY: begin
          if (fprint_reg_ack) begin
            comp_task_verified <= 1'b0;
            comp_task          <= '0;
            state              <= ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: state <= ST_IDLE;
        ST_MISMATCH: begin
          if (mismatch_clear) begin
            mismatch <= 1'b0;
            tail     <= head0;
            head1    <= head0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fprint_comparator.sv
// Self-checking bench for fprint_comparator: behavioural model compared every cycle plus literal spot checks.
module tb_fprint_comparator;

  localparam int AW = 2;
  localparam int D  = 1 << AW;
  localparam int CW = 32;
  localparam int KS = 16;
  localparam int KW = 4;
`ifdef FPRINT_OVERFLOW_DETECT_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          logical_core_id = 1'b0;
  logic          increment_head_pointer = 1'b0;
  logic          increment_hp_ack;
  logic [AW-1:0] fprint_head_pointer;
  logic [AW-1:0] comp_tail_pointer0;
  logic [AW-1:0] comp_tail_pointer1;
  logic [CW-1:0] fprint0;
  logic [CW-1:0] fprint1;
  logic [KS-1:0] checkin_reg_out = '0;
  logic          comp_task_verified;
  logic [KW-1:0] comp_task;
  logic          fprint_reg_ack = 1'b0;
  logic          mismatch;
  logic [KW-1:0] mismatch_task;
  logic          mismatch_clear = 1'b0;
  logic          overflow_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fprint_comparator #(
    .RAM_AW   (AW),
    .CRC_W    (CW),
    .KEY_SIZE (KS),
    .KEY_W    (KW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .logical_core_id        (logical_core_id),
    .increment_head_pointer (increment_head_pointer),
    .increment_hp_ack       (increment_hp_ack),
    .fprint_head_pointer    (fprint_head_pointer),
    .comp_tail_pointer0     (comp_tail_pointer0),
    .comp_tail_pointer1     (comp_tail_pointer1),
    .fprint0                (fprint0),
    .fprint1                (fprint1),
    .checkin_reg_out        (checkin_reg_out),
    .comp_task_verified     (comp_task_verified),
    .comp_task              (comp_task),
    .fprint_reg_ack         (fprint_reg_ack),
    .mismatch               (mismatch),
    .mismatch_task          (mismatch_task),
    .mismatch_clear         (mismatch_clear),
    .overflow_err           (overflow_err)
  );

  // Environment: fingerprint RAMs with synchronous read at the shared tail.
  logic [CW-1:0] mem0 [D];
  logic [CW-1:0] mem1 [D];
  logic [CW-1:0] wdata = '0;

  always @(posedge clk) begin
    fprint0 <= mem0[comp_tail_pointer0];
    fprint1 <= mem1[comp_tail_pointer1];
  end

  function automatic int lowest(input logic [KS-1:0] v);
    for (int i = 0; i < KS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Behavioural model: FIFO occupancy arithmetic plus a few phase flags.
  int m_h0 = 0, m_h1 = 0, m_t = 0, m_wait = 0, m_task = 0, m_mtask = 0;
  bit m_ack = 0, m_ovf = 0, m_ver = 0, m_cool = 0, m_mis = 0;
  int o_h0, o_h1, o_t, tgt;
  bit req, e0, e1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_h0 = 0; m_h1 = 0; m_t = 0; m_wait = 0; m_task = 0; m_mtask = 0;
      m_ack = 0; m_ovf = 0; m_ver = 0; m_cool = 0; m_mis = 0;
      for (int i = 0; i < D; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      o_h0 = m_h0; o_h1 = m_h1; o_t = m_t;
      req  = increment_head_pointer && !m_ack;
      m_ack = req;
      if (req) begin
        tgt = logical_core_id ? o_h1 : o_h0;
        if (OVF && ((tgt + 1) % D == o_t)) m_ovf = 1;
        else if (logical_core_id) begin
          mem1[o_h1] <= wdata;
          m_h1 = (o_h1 + 1) % D;
        end else begin
          mem0[o_h0] <= wdata;
          m_h0 = (o_h0 + 1) % D;
        end
      end
      e0 = (o_h0 == o_t);
      e1 = (o_h1 == o_t);
      if (m_mis) begin
        if (mismatch_clear) begin
          m_mis = 0; m_t = o_h0; m_h1 = o_h0;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (m_ver) begin
        if (fprint_reg_ack) begin
          m_ver = 0; m_cool = 1; m_task = 0;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          if (fprint0 == fprint1) m_t = (o_t + 1) % D;
          else begin
            m_mis = 1; m_mtask = lowest(checkin_reg_out); m_t = o_h0;
          end
        end
      end else if (!e0 && !e1) begin
        m_wait = 2;
      end else if (checkin_reg_out != '0 && e0 && e1) begin
        m_ver = 1; m_task = lowest(checkin_reg_out);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("ack", 32'(increment_hp_ack), 32'(m_ack));
      chk("head_ptr", 32'(fprint_head_pointer), logical_core_id ? m_h1 : m_h0);
      chk("tail0", 32'(comp_tail_pointer0), m_t);
      chk("tail1", 32'(comp_tail_pointer1), m_t);
      chk("verified", 32'(comp_task_verified), 32'(m_ver));
      chk("comp_task", 32'(comp_task), m_task);
      chk("mismatch", 32'(mismatch), 32'(m_mis));
      chk("mismatch_task", 32'(mismatch_task), m_mtask);
      chk("overflow", 32'(overflow_err), 32'(m_ovf));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic push(input logic core, input logic [CW-1:0] d);
    int k;
    k = 0;
    logical_core_id = core;
    wdata = d;
    increment_head_pointer = 1'b1;
    step();
    while (!increment_hp_ack && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (!increment_hp_ack) begin
      errors++;
      $display("FAIL push_ack_timeout: got no ack within %0d cycles required ack=1", k);
    end
    increment_head_pointer = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 32'(increment_hp_ack), 0);
    chk({tag, "_head"}, 32'(fprint_head_pointer), 0);
    chk({tag, "_tail0"}, 32'(comp_tail_pointer0), 0);
    chk({tag, "_tail1"}, 32'(comp_tail_pointer1), 0);
    chk({tag, "_verified"}, 32'(comp_task_verified), 0);
    chk({tag, "_comp_task"}, 32'(comp_task), 0);
    chk({tag, "_mismatch"}, 32'(mismatch), 0);
    chk({tag, "_mismatch_task"}, 32'(mismatch_task), 0);
    chk({tag, "_overflow"}, 32'(overflow_err), 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    step(2);
    check_zero("rst");
    reset = 1'b0;
    step();

    // Matching pair: tail advances three edges after the second ack edge.
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'hDEADBEEF);
    step();
    chk("t1_ack_pulse", 32'(increment_hp_ack), 0);
    chk("t1_tail_a", 32'(comp_tail_pointer0), 0);
    step();
    chk("t1_tail_b", 32'(comp_tail_pointer0), 0);
    step();
    chk("t1_tail_adv", 32'(comp_tail_pointer0), 1);
    chk("t1_no_mismatch", 32'(mismatch), 0);

    // Differing pair: sticky mismatch, task from lowest check-in bit.
    do_reset();
    push(1'b0, 32'h1);
    checkin_reg_out = 16'h0008;
    push(1'b1, 32'h2);
    step(3);
    chk("t2_mismatch", 32'(mismatch), 1);
    chk("t2_mismatch_task", 32'(mismatch_task), 3);
    chk("t2_tail_resync", 32'(comp_tail_pointer0), 1);
    step(4);
    chk("t2_no_verify", 32'(comp_task_verified), 0);
    chk("t2_sticky", 32'(mismatch), 1);
    checkin_reg_out = '0;
    mismatch_clear = 1'b1;
    step();
    mismatch_clear = 1'b0;
    chk("t2_cleared", 32'(mismatch), 0);
    step(2);

    // Empty FIFOs with check-ins: verify handshake and cooldown.
    do_reset();
    checkin_reg_out = 16'h0024;
    step();
    chk("t3_verified", 32'(comp_task_verified), 1);
    chk("t3_task", 32'(comp_task), 2);
    step(3);
    chk("t3_held", 32'(comp_task_verified), 1);
    chk("t3_task_held", 32'(comp_task), 2);
    fprint_reg_ack = 1'b1;
    step();
    fprint_reg_ack = 1'b0;
    checkin_reg_out = '0;
    chk("t3_cooldown", 32'(comp_task_verified), 0);
    step();
    chk("t3_idle", 32'(comp_task_verified), 0);

    // Four core-0 pushes into a depth-4 FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, 32'(i + 16));
    logical_core_id = 1'b0;
    step();
    chk("t4_head0", 32'(fprint_head_pointer), OVF ? 3 : 0);
    chk("t4_overflow", 32'(overflow_err), OVF ? 1 : 0);

    // Reset during verify with an increment pending.
    do_reset();
    checkin_reg_out = 16'h0001;
    step();
    chk("t5_verified", 32'(comp_task_verified), 1);
    logical_core_id = 1'b1;
    increment_head_pointer = 1'b1;
    step();
    reset = 1'b1;
    #1;
    check_zero("t5_async");
    step();
    check_zero("t5_held");
    increment_head_pointer = 1'b0;
    checkin_reg_out = '0;
    reset = 1'b0;
    step();
    chk("t5_after_verified", 32'(comp_task_verified), 0);
    chk("t5_after_tail", 32'(comp_tail_pointer0), 0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
